// File: rtl/stb_cmd_queue.sv
// rtl/stb_cmd_queue.sv - command FIFO and one-at-a-time issuer for the burst store engine
// Optional completion watchdog: define STB_CMDQ_TIMEOUT_EN.
module stb_cmd_queue #(
    parameter int SMC_COUNT      = 6,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_WIDTH    = 8,
    parameter int UR_ADDR_WIDTH  = 11,
    parameter int UR_ID_WIDTH    = 3,
    parameter int DEPTH          = 4,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [SMC_COUNT-1:0]       cmd_smc_strb,
    input  logic [3:0]                 cmd_byte_strb,
    input  logic [BURST_WIDTH-1:0]     cmd_brst,
    input  logic [ADDR_WIDTH-1:0]      cmd_gr_base_addr,
    input  logic [UR_ID_WIDTH-1:0]     cmd_ur_id,
    input  logic [UR_ADDR_WIDTH-1:0]   cmd_ur_addr,
    input  logic [TAG_WIDTH-1:0]       cmd_tag,
    output logic                       stb_u_valid,
    output logic [SMC_COUNT-1:0]       stb_u_smc_strb,
    output logic [3:0]                 stb_u_byte_strb,
    output logic [BURST_WIDTH-1:0]     stb_u_brst,
    output logic [ADDR_WIDTH-1:0]      stb_u_gr_base_addr,
    output logic [UR_ID_WIDTH-1:0]     stb_u_ur_id,
    output logic [UR_ADDR_WIDTH-1:0]   stb_u_ur_addr,
    input  logic                       stb_d_valid,
    input  logic                       stb_d_done,
    output logic                       rsp_valid,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    output logic                       rsp_err,
    input  logic                       rsp_ready,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = SMC_COUNT + 4 + BURST_WIDTH + ADDR_WIDTH + UR_ID_WIDTH
                      + UR_ADDR_WIDTH + TAG_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t                     state, state_d;
    logic [EW-1:0]              mem [DEPTH];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic                       push, pop, load_u, rsp_load, rsp_err_d;

    logic [SMC_COUNT-1:0]       h_smc;
    logic [3:0]                 h_byte;
    logic [BURST_WIDTH-1:0]     h_brst;
    logic [ADDR_WIDTH-1:0]      h_addr;
    logic [UR_ID_WIDTH-1:0]     h_id;
    logic [UR_ADDR_WIDTH-1:0]   h_uaddr;
    logic [TAG_WIDTH-1:0]       h_tag;

    assign {h_smc, h_byte, h_brst, h_addr, h_id, h_uaddr, h_tag} = mem[rd_ptr];

    // Ready comes from the registered count only, so a full queue never accepts even on a pop cycle
    assign cmd_ready   = (count != FULL);
    assign push        = cmd_valid && cmd_ready;
    assign q_count     = count;
    assign stb_u_valid = (state == ISSUE);
    assign rsp_valid   = (state == RESP);
    assign busy        = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_smc_strb, cmd_byte_strb, cmd_brst, cmd_gr_base_addr,
                            cmd_ur_id, cmd_ur_addr, cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef STB_CMDQ_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES);
    logic [TOW-1:0] to_cnt;
    logic           to_hit;

    assign to_hit = (to_cnt == TOW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        load_u    = 1'b0;
        rsp_load  = 1'b0;
        rsp_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    // A zero-length burst would hang the engine; answer it here instead
                    if (h_brst == '0) begin
                        state_d   = RESP;
                        pop       = 1'b1;
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        load_u  = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (stb_d_valid && stb_d_done) begin
                    state_d  = RESP;
                    pop      = 1'b1;
                    rsp_load = 1'b1;
                end
`ifdef STB_CMDQ_TIMEOUT_EN
                else if (to_hit) begin
                    state_d   = RESP;
                    pop       = 1'b1;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_u_smc_strb     <= '0;
            stb_u_byte_strb    <= '0;
            stb_u_brst         <= '0;
            stb_u_gr_base_addr <= '0;
            stb_u_ur_id        <= '0;
            stb_u_ur_addr      <= '0;
            rsp_tag            <= '0;
            rsp_err            <= 1'b0;
        end else begin
            if (load_u) begin
                stb_u_smc_strb     <= h_smc;
                stb_u_byte_strb    <= h_byte;
                stb_u_brst         <= h_brst;
                stb_u_gr_base_addr <= h_addr;
                stb_u_ur_id        <= h_id;
                stb_u_ur_addr      <= h_uaddr;
            end
            if (rsp_load) begin
                rsp_tag <= h_tag;
                rsp_err <= rsp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_stb_cmd_queue.sv
// tb/tb_stb_cmd_queue.sv - directed self-checking bench for stb_cmd_queue
module tb_stb_cmd_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_smc_strb;
    logic [3:0]  cmd_byte_strb;
    logic [7:0]  cmd_brst;
    logic [31:0] cmd_gr_base_addr;
    logic [2:0]  cmd_ur_id;
    logic [10:0] cmd_ur_addr;
    logic [3:0]  cmd_tag;
    logic        stb_u_valid;
    logic [5:0]  stb_u_smc_strb;
    logic [3:0]  stb_u_byte_strb;
    logic [7:0]  stb_u_brst;
    logic [31:0] stb_u_gr_base_addr;
    logic [2:0]  stb_u_ur_id;
    logic [10:0] stb_u_ur_addr;
    logic        stb_d_valid;
    logic        stb_d_done;
    logic        rsp_valid;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        rsp_ready;
    logic [2:0]  q_count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stb_cmd_queue #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_smc_strb(cmd_smc_strb), .cmd_byte_strb(cmd_byte_strb), .cmd_brst(cmd_brst),
        .cmd_gr_base_addr(cmd_gr_base_addr), .cmd_ur_id(cmd_ur_id),
        .cmd_ur_addr(cmd_ur_addr), .cmd_tag(cmd_tag),
        .stb_u_valid(stb_u_valid), .stb_u_smc_strb(stb_u_smc_strb),
        .stb_u_byte_strb(stb_u_byte_strb), .stb_u_brst(stb_u_brst),
        .stb_u_gr_base_addr(stb_u_gr_base_addr), .stb_u_ur_id(stb_u_ur_id),
        .stb_u_ur_addr(stb_u_ur_addr),
        .stb_d_valid(stb_d_valid), .stb_d_done(stb_d_done),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .q_count(q_count), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Fields derived from the tag so each command is distinguishable at the engine port
    task automatic drive_cmd(input logic [3:0] tag, input logic [7:0] brst);
        cmd_valid        = 1'b1;
        cmd_tag          = tag;
        cmd_brst         = brst;
        cmd_smc_strb     = 6'(tag + 1);
        cmd_byte_strb    = tag;
        cmd_gr_base_addr = 32'h1000_0000 + 32'(tag) * 16;
        cmd_ur_id        = 3'(tag);
        cmd_ur_addr      = 11'(tag) * 3;
    endtask

    task automatic wait_issue(input string name);
        int k;
        k = 0;
        while (stb_u_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, {63'b0, stb_u_valid}, 64'd1);
    endtask

    task automatic engine_done();
        @(negedge clk);
        stb_d_valid = 1'b1;
        stb_d_done  = 1'b1;
        @(negedge clk);
        stb_d_valid = 1'b0;
        stb_d_done  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; stb_d_valid = 1'b0; stb_d_done = 1'b0; rsp_ready = 1'b1;
        drive_cmd(4'd0, 8'd0);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_q_count", q_count, 0);
        check("rst_stb_u_valid", stb_u_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_stb_u_brst", stb_u_brst, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single command: tag 3, brst 4
        drive_cmd(4'd3, 8'd4);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t1_q_count", q_count, 1);
        check("t1_no_early_issue", stb_u_valid, 0);
        @(negedge clk);
        check("t1_issue", stb_u_valid, 1);
        check("t1_brst", stb_u_brst, 8'd4);
        check("t1_addr", stb_u_gr_base_addr, 32'h1000_0030);
        check("t1_smc", stb_u_smc_strb, 6'd4);
        check("t1_byte", stb_u_byte_strb, 4'd3);
        check("t1_ur_id", stb_u_ur_id, 3'd3);
        check("t1_ur_addr", stb_u_ur_addr, 11'd9);
        @(negedge clk);
        check("t1_pulse_one_cycle", stb_u_valid, 0);
        check("t1_brst_held", stb_u_brst, 8'd4);
        check("t1_busy", busy, 1);
        stb_d_valid = 1'b1;
        @(negedge clk);
        stb_d_valid = 1'b0;
        check("t1_valid_no_done_ignored", rsp_valid, 0);
        repeat (15) @(negedge clk);
        engine_done();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_tag", rsp_tag, 4'd3);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_popped", q_count, 0);
        @(negedge clk);
        check("t1_rsp_one_cycle", rsp_valid, 0);
        check("t1_idle", busy, 0);

        // Fill: tags 0..3 fill the queue, tag 4 waits for space
        for (int i = 0; i < 4; i++) begin
            drive_cmd(4'(i), 8'(i + 1));
            @(negedge clk);
        end
        drive_cmd(4'd4, 8'd5);
        check("fill_q_count", q_count, 4);
        check("fill_not_ready", cmd_ready, 0);
        repeat (3) @(negedge clk);
        check("fill_hold_count", q_count, 4);
        check("fill_hold_not_ready", cmd_ready, 0);
        check("fill_head_brst", stb_u_brst, 8'd1);
        engine_done();
        check("fill_rsp_tag0", rsp_tag, 4'd0);
        check("fill_count_after_pop", q_count, 3);
        check("fill_ready_again", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("fill_fifth_accepted", q_count, 4);
        for (int i = 1; i < 5; i++) begin
            wait_issue("fill_issue");
            check("fill_order_brst", stb_u_brst, 64'(i + 1));
            engine_done();
            check("fill_order_tag", rsp_tag, 64'(i));
            check("fill_order_err", rsp_err, 0);
        end
        @(negedge clk);

        // Zero burst rejected; its pop coincides with a push
        drive_cmd(4'd7, 8'd0);
        @(negedge clk);
        drive_cmd(4'd5, 8'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("zb_rsp_valid", rsp_valid, 1);
        check("zb_rsp_tag", rsp_tag, 4'd7);
        check("zb_rsp_err", rsp_err, 1);
        check("zb_push_pop_count", q_count, 1);
        check("zb_no_issue", stb_u_valid, 0);
        @(negedge clk);
        check("zb_idle_no_issue", stb_u_valid, 0);
        wait_issue("zb_next_issue");
        check("zb_next_brst", stb_u_brst, 8'd2);
        engine_done();
        check("zb_next_tag", rsp_tag, 4'd5);
        check("zb_next_err", rsp_err, 0);
        @(negedge clk);

        // Response backpressure
        rsp_ready = 1'b0;
        drive_cmd(4'd9, 8'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_issue("bp_issue");
        engine_done();
        drive_cmd(4'd10, 8'd6);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_held", rsp_valid, 1);
            check("bp_tag_held", rsp_tag, 4'd9);
            check("bp_no_issue", stb_u_valid, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", rsp_valid, 0);
        @(negedge clk);
        check("bp_next_issue", stb_u_valid, 1);
        check("bp_next_brst", stb_u_brst, 8'd6);

        // Reset while waiting for the engine with three queued entries
        drive_cmd(4'd11, 8'd1);
        @(negedge clk);
        drive_cmd(4'd12, 8'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rm_q_count", q_count, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("rm_q_flushed", q_count, 0);
        check("rm_rsp_valid", rsp_valid, 0);
        check("rm_stb_u_valid", stb_u_valid, 0);
        check("rm_cmd_ready", cmd_ready, 1);
        check("rm_busy", busy, 0);
        check("rm_brst_cleared", stb_u_brst, 0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_cmd(4'd13, 8'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_issue("to_issue");
`ifdef STB_CMDQ_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("to_still_waiting", rsp_valid, 0);
        end
        @(negedge clk);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_tag", rsp_tag, 4'd13);
        check("to_popped", q_count, 0);
        stb_d_valid = 1'b1;
        stb_d_done  = 1'b1;
        @(negedge clk);
        stb_d_valid = 1'b0;
        stb_d_done  = 1'b0;
        check("to_late_done_ignored", rsp_valid, 0);
        check("to_idle", busy, 0);
`else
        repeat (40) @(negedge clk);
        check("nto_still_waiting", rsp_valid, 0);
        check("nto_busy", busy, 1);
        engine_done();
        check("nto_rsp_valid", rsp_valid, 1);
        check("nto_rsp_tag", rsp_tag, 4'd13);
        check("nto_rsp_err", rsp_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
